retro_assoc_fill_cache: RTL and testbench
=========================================

// Module: retro_assoc_fill_cache
// PURPOSE
//  Parametrised successor to the single-cycle cartridge cache. N-way set-associative read cache with
//  its own miss FSM: it fills whole lines from multi-cycle backing storage and needs no controller.
//  Writes are write-through with hit update. Sits between core memory port and cartridge/SDRAM.
//  Busy drives the core's CCCU Delay.
// PARAMETERS
//  AddressBusWidth  16  core byte-address width
//  DataBusWidth      1  bytes per beat (core and backing side identical)
//  CacheLineBits     4  log2 bytes per line
//  CacheIndexBits    6  log2 sets
//  CacheWays         2  associativity, power of two, 1..8
// PORTS
//  Clk          in   1          single clock; all state on rising edge
//  Reset        in   1          synchronous, active-high
//  Access       in   1          core request; accepted when Access && !Busy
//  Write        in   1          request is a write (sampled on accept)
//  Address      in   AW         byte address (sampled on accept)
//  Din          in   8*DBW      write data (sampled on accept)
//  Dout         out  8*DBW      read data, valid while DataReady
//  DataReady    out  1          1-cycle pulse: read data valid / write retired
//  Busy         out  1          cache cannot accept; core must hold/Delay
//  Flush        in   1          invalidate all lines (pulse; honoured in IDLE only)
//  MemAccess    out  1          backing request; held until MemReady
//  MemWrite     out  1          backing request is a write
//  MemAddress   out  AW         backing byte address
//  MemDout      out  8*DBW      backing write data
//  MemReady     in   1          backing accepted request this cycle
//  MemDin       in   8*DBW      backing read data
//  MemDataReady in   1          backing read data valid (one pulse per accepted read)
// BEHAVIOUR
//  Reset: state IDLE; all Valid bits 0; RR counter 0; DataReady=0, Busy=0, MemAccess=0, MemWrite=0,
//   Dout/MemAddress/MemDout=0. Reset mid-fill/mid-write abandons it; a late MemDataReady is ignored.
//  Address split: Tag=[AW-1:IB+LB], Index=[IB+LB-1:LB], Offset=[LB-1:0]; TagLength=AW-IB-LB.
//  States: IDLE, LOOKUP, FILL_REQ, FILL_WAIT, RESPOND, WT_REQ, FLUSH.
//  IDLE: Busy=0. Accept -> register request, LOOKUP. Flush && !Access -> FLUSH. Access wins over Flush.
//  LOOKUP (Busy=1): compare registered tag against all ways of set.
//   read hit  -> DataReady=1, Dout=hit data this cycle, -> IDLE (hit latency 1 cycle after accept).
//   read miss -> pick victim: lowest-numbered invalid way, else RR counter; -> FILL_REQ.
//   write     -> if hit, update byte(s) in hit way now; -> WT_REQ (miss: no allocate).
//  FILL_REQ: MemAccess=1, MemWrite=0, MemAddress={Tag,Index,beat*DBW}; beats from offset 0 upward;
//   MemReady -> FILL_WAIT. Exactly one outstanding backing read.
//  FILL_WAIT: MemDataReady -> write beat into victim way; last beat (2**LB/DBW-1) -> set Valid,
//   write Tag, RR counter += 1 (wraps mod CacheWays), -> RESPOND; else beat+1, -> FILL_REQ.
//   Valid stays 0 for the victim during the whole fill.
//  RESPOND: DataReady=1, Dout=requested beat from filled line, -> IDLE.
//  WT_REQ: MemAccess=1, MemWrite=1, MemAddress/MemDout = registered request; MemReady ->
//   DataReady=1 same cycle, -> IDLE.
//  FLUSH: Busy=1, clears all Valid bits in one cycle, -> IDLE. Tags/data untouched.
//  Busy=1 in every state except IDLE. DataReady never asserted in IDLE. Core must not change
//   request while Busy; new Access while Busy is not accepted (not an error).
//  Misaligned beats: Address offset is truncated to a DBW boundary.
//  Single-beat line (LB==log2 DBW): FILL_WAIT goes straight to RESPOND after one beat.
//  MemReady/MemDataReady asserted outside FILL_REQ/FILL_WAIT/WT_REQ are ignored.
// STRUCTURE
//  Package retro_cache_pkg: cache_state_e enum, function tag_of/index_of/offset_of, TagLength calc.
//  Sub-module retro_cache_way_ram: one way's data array (2**(IB+LB)/DBW x 8*DBW, 1 write port,
//   async read so LOOKUP hit data is same-cycle); instantiated CacheWays times via generate.
//  Tags, Valid and RR counter are flops in the top module.
// TESTING (defaults; backing model: MemReady after 2 cycles, MemDataReady 3 cycles after accept)
//  1 Reset, read 0x1234 -> Busy, 16 MemAccess reads 0x1230..0x123F, RESPOND Dout=mem[0x1234], Busy drops.
//  2 Re-read 0x1235 -> DataReady 1 cycle after accept, no MemAccess, Dout=mem[0x1235].
//  3 Read 0x1234, 0x5234, 0x9234 (same set, 2 ways) -> third evicts way0; re-read 0x1234 misses,
//    0x5234 still hits.
//  4 Write 0xAB to 0x1236 after fill -> one MemWrite at 0x1236 data 0xAB; read 0x1236 hits =0xAB.
//    Write to uncached 0x7000 -> MemWrite only, later read 0x7000 misses.
//  5 Flush pulse in IDLE -> Busy 1 cycle; read 0x1234 then misses and refills.
//  6 Reset asserted during beat 7 of a fill -> Busy=0 next cycle, late MemDataReady ignored,
//    read 0x1234 misses and performs a full 16-beat fill.

Source files
------------

// File: rtl/retro_cache_pkg.sv
// Shared types and address-split helpers for the set-associative fill cache.
package retro_cache_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_FILL_REQ,
      ST_FILL_WAIT,
      ST_RESPOND,
      ST_WT_REQ,
      ST_FLUSH
   } cache_state_e;

   function automatic int unsigned tag_length(int unsigned aw, int unsigned ib, int unsigned lb);
      return aw - ib - lb;
   endfunction

   function automatic logic [31:0] tag_of(logic [31:0] addr, int unsigned ib, int unsigned lb);
      return addr >> (ib + lb);
   endfunction

   function automatic logic [31:0] index_of(logic [31:0] addr, int unsigned ib, int unsigned lb);
      return (addr >> lb) & ((32'd1 << ib) - 32'd1);
   endfunction

   function automatic logic [31:0] offset_of(logic [31:0] addr, int unsigned lb);
      return addr & ((32'd1 << lb) - 32'd1);
   endfunction

endpackage

// File: rtl/retro_assoc_fill_cache_if.sv
// Core-side and backing-side bus of the fill cache.
interface retro_assoc_fill_cache_if #(
   parameter int unsigned AddressBusWidth = 16,
   parameter int unsigned DataBusWidth    = 1
);
   logic                          access;
   logic                          write;
   logic [AddressBusWidth-1:0]    address;
   logic [8*DataBusWidth-1:0]     din;
   logic [8*DataBusWidth-1:0]     dout;
   logic                          data_ready;
   logic                          busy;
   logic                          flush;
   logic                          mem_access;
   logic                          mem_write;
   logic [AddressBusWidth-1:0]    mem_address;
   logic [8*DataBusWidth-1:0]     mem_dout;
   logic                          mem_ready;
   logic [8*DataBusWidth-1:0]     mem_din;
   logic                          mem_data_ready;

   // Cache side
   modport slave (
      input  access, write, address, din, flush, mem_ready, mem_din, mem_data_ready,
      output dout, data_ready, busy, mem_access, mem_write, mem_address, mem_dout
   );

   // Core plus backing-storage side
   modport master (
      output access, write, address, din, flush, mem_ready, mem_din, mem_data_ready,
      input  dout, data_ready, busy, mem_access, mem_write, mem_address, mem_dout
   );
endinterface

// File: rtl/retro_cache_way_ram.sv
// One way's data array: single write port, asynchronous read port.
module retro_cache_way_ram #(
   parameter int unsigned AddrBits = 10,
   parameter int unsigned DataBits = 8
) (
   input  logic                clk,
   input  logic                we,
   input  logic [AddrBits-1:0] waddr,
   input  logic [DataBits-1:0] wdata,
   input  logic [AddrBits-1:0] raddr,
   output logic [DataBits-1:0] rdata
);
   logic [DataBits-1:0] mem [2**AddrBits];

   // Beat write
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/retro_assoc_fill_cache.sv
// N-way set-associative read cache with its own line-fill FSM; write-through, no write allocate.
module retro_assoc_fill_cache
   import retro_cache_pkg::*;
#(
   parameter int unsigned AddressBusWidth = 16,
   parameter int unsigned DataBusWidth    = 1,
   parameter int unsigned CacheLineBits   = 4,
   parameter int unsigned CacheIndexBits  = 6,
   parameter int unsigned CacheWays       = 2
) (
   input logic                    clk,
   input logic                    rst,
   retro_assoc_fill_cache_if.slave bus
);
   localparam int unsigned AW    = AddressBusWidth;
   localparam int unsigned DW    = 8 * DataBusWidth;
   localparam int unsigned LB    = CacheLineBits;
   localparam int unsigned IB    = CacheIndexBits;
   localparam int unsigned WAYS  = CacheWays;
   localparam int unsigned DB    = $clog2(DataBusWidth);
   localparam int unsigned BW    = LB - DB;
   localparam int unsigned BEATS = 2 ** BW;
   localparam int unsigned BCW   = (BW > 0) ? BW : 1;
   localparam int unsigned SETS  = 2 ** IB;
   localparam int unsigned RAW   = IB + BW;
   localparam int unsigned TL    = tag_length(AW, IB, LB);
   localparam int unsigned WAYW  = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

   cache_state_e state, state_nx;

   logic            req_write;
   logic [AW-1:0]   req_addr;
   logic [DW-1:0]   req_data;
   logic [TL-1:0]   req_tag;
   logic [IB-1:0]   req_index;
   logic [BCW-1:0]  req_beat;
   logic [AW-1:0]   line_base;

   logic [BCW-1:0]  fill_beat;
   logic [WAYW-1:0] victim, victim_pick, rr, hit_way;
   logic            hit, free_found;

   logic [SETS-1:0] valid [WAYS];
   logic [TL-1:0]   tags  [WAYS][SETS];

   logic [DW-1:0]   way_rdata [WAYS];
   logic [WAYS-1:0] way_we;
   logic [RAW-1:0]  raddr, waddr;
   logic [DW-1:0]   wdata;

   logic            busy, data_ready, mem_access, mem_write;
   logic [AW-1:0]   mem_address;
   logic [DW-1:0]   mem_dout, dout;
   logic            fill_done;

   assign req_tag   = TL'(tag_of(32'(req_addr), IB, LB));
   assign req_index = IB'(index_of(32'(req_addr), IB, LB));
   assign req_beat  = BCW'(offset_of(32'(req_addr), LB) >> DB);
   assign line_base = req_addr & ~AW'(2 ** LB - 1);
   assign raddr     = RAW'(32'(req_index) * BEATS + 32'(req_beat));
   assign fill_done = (state == ST_FILL_WAIT) && bus.mem_data_ready && (fill_beat == LAST_BEAT);

   // Tag compare across all ways of the addressed set; lowest matching way wins
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (!hit && valid[w][req_index] && tags[w][req_index] == req_tag) begin
            hit     = 1'b1;
            hit_way = WAYW'(w);
         end
      end
   end

   // Victim choice: lowest invalid way, otherwise the round-robin pointer
   always_comb begin
      free_found  = 1'b0;
      victim_pick = rr;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (!free_found && !valid[w][req_index]) begin
            free_found  = 1'b1;
            victim_pick = WAYW'(w);
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // Next state and bus outputs
   always_comb begin
      state_nx    = state;
      busy        = 1'b1;
      data_ready  = 1'b0;
      mem_access  = 1'b0;
      mem_write   = 1'b0;
      mem_address = '0;
      mem_dout    = '0;
      dout        = '0;
      unique case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (bus.access)     state_nx = ST_LOOKUP;
            else if (bus.flush) state_nx = ST_FLUSH;
         end
         ST_LOOKUP: begin
            if (req_write) begin
               state_nx = ST_WT_REQ;
            end else if (hit) begin
               data_ready = 1'b1;
               dout       = way_rdata[hit_way];
               state_nx   = ST_IDLE;
            end else begin
               state_nx = ST_FILL_REQ;
            end
         end
         ST_FILL_REQ: begin
            mem_access  = 1'b1;
            mem_address = line_base | AW'(32'(fill_beat) << DB);
            if (bus.mem_ready) state_nx = ST_FILL_WAIT;
         end
         ST_FILL_WAIT: begin
            if (bus.mem_data_ready) state_nx = (fill_beat == LAST_BEAT) ? ST_RESPOND : ST_FILL_REQ;
         end
         ST_RESPOND: begin
            data_ready = 1'b1;
            dout       = way_rdata[victim];
            state_nx   = ST_IDLE;
         end
         ST_WT_REQ: begin
            mem_access  = 1'b1;
            mem_write   = 1'b1;
            mem_address = req_addr;
            mem_dout    = req_data;
            if (bus.mem_ready) begin
               data_ready = 1'b1;
               state_nx   = ST_IDLE;
            end
         end
         ST_FLUSH: state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   // Request capture, victim/beat tracking, valid bits and round-robin pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         req_write <= 1'b0;
         req_addr  <= '0;
         req_data  <= '0;
         victim    <= '0;
         fill_beat <= '0;
         rr        <= '0;
         for (int unsigned w = 0; w < WAYS; w++) valid[w] <= '0;
      end else begin
         if (state == ST_IDLE && bus.access) begin
            req_write <= bus.write;
            req_addr  <= bus.address & ~AW'(DataBusWidth - 1);
            req_data  <= bus.din;
         end
         // The victim is invalidated up front so a partial line is never seen as a hit
         if (state == ST_LOOKUP && !req_write && !hit) begin
            victim    <= victim_pick;
            fill_beat <= '0;
            valid[victim_pick][req_index] <= 1'b0;
         end
         if (state == ST_FILL_WAIT && bus.mem_data_ready && fill_beat != LAST_BEAT)
            fill_beat <= fill_beat + 1'b1;
         if (fill_done) begin
            valid[victim][req_index] <= 1'b1;
            rr <= (rr == WAYW'(WAYS - 1)) ? '0 : rr + 1'b1;
         end
         if (state == ST_FLUSH)
            for (int unsigned w = 0; w < WAYS; w++) valid[w] <= '0;
      end
   end

   // Tag store, written when a fill completes
   always_ff @(posedge clk) begin
      if (!rst && fill_done) tags[victim][req_index] <= req_tag;
   end

   // Way RAM write steering: fill beats from backing storage, or write-hit update
   always_comb begin
      way_we = '0;
      waddr  = raddr;
      wdata  = req_data;
      if (state == ST_LOOKUP && req_write && hit) way_we[hit_way] = 1'b1;
      if (state == ST_FILL_WAIT && bus.mem_data_ready) begin
         way_we[victim] = 1'b1;
         waddr          = RAW'(32'(req_index) * BEATS + 32'(fill_beat));
         wdata          = bus.mem_din;
      end
   end

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      retro_cache_way_ram #(.AddrBits(RAW), .DataBits(DW)) u_ram (
         .clk   (clk),
         .we    (way_we[w]),
         .waddr (waddr),
         .wdata (wdata),
         .raddr (raddr),
         .rdata (way_rdata[w])
      );
   end

   assign bus.busy        = busy;
   assign bus.data_ready  = data_ready;
   assign bus.dout        = dout;
   assign bus.mem_access  = mem_access;
   assign bus.mem_write   = mem_write;
   assign bus.mem_address = mem_address;
   assign bus.mem_dout    = mem_dout;
endmodule

// File: tb/tb_retro_assoc_fill_cache.sv
// Bench for retro_assoc_fill_cache with default parameters and a latency-modelled backing store.
module tb_retro_assoc_fill_cache;

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic        exp_hit;
   } vec_t;

   logic clk, rst;

   retro_assoc_fill_cache_if bus ();

   retro_assoc_fill_cache dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Backing storage as seen by the DUT, and the bench's own view of what memory should hold
   logic [7:0]  bmem    [65536];
   logic [7:0]  ref_mem [65536];
   logic [15:0] rd_log [$];
   logic [15:0] wr_a   [$];
   logic [7:0]  wr_d   [$];
   int unsigned wait_cnt  = 0;
   int unsigned pend_cnt  = 0;
   logic        pend      = 1'b0;
   logic [15:0] pend_addr = '0;

   // Reference cache state: per set, two ways of {valid, tag}; one global round-robin pointer
   logic        mv [64][2];
   logic [5:0]  mt [64][2];
   int unsigned mrr;

   // Backing store: MemReady on the third cycle of a held request, read data 3 cycles after accept
   always @(negedge clk) begin
      bus.mem_ready      = 1'b0;
      bus.mem_data_ready = 1'b0;
      bus.mem_din        = '0;
      if (pend) begin
         pend_cnt--;
         if (pend_cnt == 0) begin
            pend               = 1'b0;
            bus.mem_data_ready = 1'b1;
            bus.mem_din        = bmem[pend_addr];
         end
      end
      if (bus.mem_access) begin
         if (wait_cnt == 2) begin
            wait_cnt      = 0;
            bus.mem_ready = 1'b1;
            if (bus.mem_write) begin
               wr_a.push_back(bus.mem_address);
               wr_d.push_back(bus.mem_dout);
               bmem[bus.mem_address] = bus.mem_dout;
            end else begin
               rd_log.push_back(bus.mem_address);
               pend      = 1'b1;
               pend_cnt  = 3;
               pend_addr = bus.mem_address;
            end
         end else begin
            wait_cnt++;
         end
      end else begin
         wait_cnt = 0;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void model_clear(input logic clr_rr);
      for (int s = 0; s < 64; s++)
         for (int w = 0; w < 2; w++) mv[s][w] = 1'b0;
      if (clr_rr) mrr = 0;
   endfunction

   // Returns whether the access hits; read misses allocate a line
   function automatic logic model_access(input logic wr, input logic [15:0] a);
      int          s;
      logic [5:0]  t;
      int          v;
      s = int'(a[9:4]);
      t = a[15:10];
      for (int w = 0; w < 2; w++)
         if (mv[s][w] && mt[s][w] == t) return 1'b1;
      if (wr) return 1'b0;
      v = -1;
      for (int w = 0; w < 2; w++)
         if (v < 0 && !mv[s][w]) v = w;
      if (v < 0) v = int'(mrr);
      mv[s][v] = 1'b1;
      mt[s][v] = t;
      mrr = (mrr + 1) % 2;
      return 1'b0;
   endfunction

   task automatic xact(input logic wr, input logic [15:0] a, input logic [7:0] d,
                       output logic [7:0] rd, output int lat, output logic ok);
      rd_log.delete();
      wr_a.delete();
      wr_d.delete();
      bus.write   = wr;
      bus.address = a;
      bus.din     = d;
      bus.access  = 1'b1;
      tick();
      bus.access = 1'b0;
      bus.flush  = 1'b0;
      lat = 1;
      ok  = 1'b0;
      rd  = '0;
      while (!ok && lat < 400) begin
         if (bus.data_ready) begin
            ok = 1'b1;
            rd = bus.dout;
         end else begin
            tick();
            lat++;
         end
      end
      tick();
   endtask

   task automatic run_xact(input string nm, input logic wr, input logic [15:0] a,
                           input logic [7:0] d, input logic exp_hit);
      logic [7:0]  rd;
      int          lat;
      logic        ok;
      logic [15:0] base;
      int          bad;
      xact(wr, a, d, rd, lat, ok);
      check($sformatf("%s done", nm), 32'(ok), 32'd1);
      if (wr) begin
         ref_mem[a] = d;
         check($sformatf("%s wr count", nm), wr_a.size(), 1);
         check($sformatf("%s rd count", nm), rd_log.size(), 0);
         if (wr_a.size() == 1) begin
            check($sformatf("%s wr addr", nm), 32'(wr_a[0]), 32'(a));
            check($sformatf("%s wr data", nm), 32'(wr_d[0]), 32'(d));
         end
      end else begin
         check($sformatf("%s data", nm), 32'(rd), 32'(ref_mem[a]));
         check($sformatf("%s beats", nm), rd_log.size(), exp_hit ? 0 : 16);
         check($sformatf("%s no write", nm), wr_a.size(), 0);
         if (exp_hit) begin
            check($sformatf("%s hit latency", nm), lat, 1);
         end else begin
            base = a & 16'hFFF0;
            bad  = 0;
            foreach (rd_log[k]) if (rd_log[k] != base + 16'(k)) bad++;
            check($sformatf("%s fill order", nm), bad, 0);
         end
      end
      check($sformatf("%s idle after", nm), {bus.busy, bus.data_ready}, 0);
   endtask

   initial begin
      vec_t        vecs [15];
      logic [7:0]  v;
      int          n;
      int          bad;
      logic [15:0] a;
      logic [5:0]  idx;
      logic        wr, eh;
      logic [7:0]  d;

      vecs[0]  = '{1'b0, 16'h1234, 8'h00, 1'b0};
      vecs[1]  = '{1'b0, 16'h1235, 8'h00, 1'b1};
      vecs[2]  = '{1'b0, 16'h5234, 8'h00, 1'b0};
      vecs[3]  = '{1'b0, 16'h9234, 8'h00, 1'b0};
      vecs[4]  = '{1'b0, 16'h5234, 8'h00, 1'b1};
      vecs[5]  = '{1'b0, 16'h1234, 8'h00, 1'b0};
      vecs[6]  = '{1'b0, 16'h9234, 8'h00, 1'b1};
      vecs[7]  = '{1'b1, 16'h1236, 8'hAB, 1'b1};
      vecs[8]  = '{1'b0, 16'h1236, 8'h00, 1'b1};
      vecs[9]  = '{1'b1, 16'h7000, 8'h5C, 1'b0};
      vecs[10] = '{1'b0, 16'h7000, 8'h00, 1'b0};
      vecs[11] = '{1'b0, 16'hFFFF, 8'h00, 1'b0};
      vecs[12] = '{1'b0, 16'hFFF0, 8'h00, 1'b1};
      vecs[13] = '{1'b0, 16'h0000, 8'h00, 1'b0};
      vecs[14] = '{1'b0, 16'h7000, 8'h00, 1'b1};

      bus.access  = 1'b0;
      bus.write   = 1'b0;
      bus.address = '0;
      bus.din     = '0;
      bus.flush   = 1'b0;
      for (int i = 0; i < 65536; i++) begin
         v = 8'($urandom);
         bmem[i]    = v;
         ref_mem[i] = v;
      end

      rst = 1'b1;
      model_clear(1'b1);
      repeat (3) tick();
      check("reset busy", 32'(bus.busy), 0);
      check("reset data_ready", 32'(bus.data_ready), 0);
      check("reset dout", 32'(bus.dout), 0);
      check("reset mem_access", 32'(bus.mem_access), 0);
      check("reset mem_write", 32'(bus.mem_write), 0);
      check("reset mem_address", 32'(bus.mem_address), 0);
      check("reset mem_dout", 32'(bus.mem_dout), 0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 15; i++) begin
         void'(model_access(vecs[i].wr, vecs[i].addr));
         run_xact($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_hit);
      end

      // Access and Flush together: the access is served and the cache keeps its contents
      bus.flush = 1'b1;
      void'(model_access(1'b0, 16'h1236));
      run_xact("acc_over_flush", 1'b0, 16'h1236, 8'h00, 1'b1);
      void'(model_access(1'b0, 16'h1234));
      run_xact("still_cached", 1'b0, 16'h1234, 8'h00, 1'b1);

      // Flush pulse: one busy cycle, then the line must be refilled
      bus.flush = 1'b1;
      tick();
      check("flush busy", 32'(bus.busy), 1);
      bus.flush = 1'b0;
      tick();
      check("flush done", 32'(bus.busy), 0);
      model_clear(1'b0);
      void'(model_access(1'b0, 16'h1234));
      run_xact("refill", 1'b0, 16'h1234, 8'h00, 1'b0);

      // Reset during beat 7 of a fill
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      tick();
      model_clear(1'b0);
      rd_log.delete();
      bus.address = 16'h1234;
      bus.write   = 1'b0;
      bus.access  = 1'b1;
      tick();
      bus.access = 1'b0;
      n = 0;
      while (rd_log.size() < 8 && n < 500) begin
         tick();
         n++;
      end
      check("beat7 reached", rd_log.size(), 8);
      rst = 1'b1;
      tick();
      check("abort busy", 32'(bus.busy), 0);
      check("abort mem_access", 32'(bus.mem_access), 0);
      check("abort data_ready", 32'(bus.data_ready), 0);
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.data_ready || bus.busy) bad++;
      end
      check("late data ignored", bad, 0);
      model_clear(1'b1);
      void'(model_access(1'b0, 16'h1234));
      run_xact("after_abort", 1'b0, 16'h1234, 8'h00, 1'b0);

      // Random traffic against the reference model
      for (int i = 0; i < 200 && errors < 20; i++) begin
         n = $urandom_range(0, 2);
         idx = (n == 0) ? 6'h23 : (n == 1) ? 6'h00 : 6'($urandom);
         a  = {6'($urandom_range(0, 3)), idx, 4'($urandom)};
         wr = ($urandom_range(0, 3) == 0);
         d  = 8'($urandom);
         if ($urandom_range(0, 19) == 0) begin
            bus.flush = 1'b1;
            tick();
            bus.flush = 1'b0;
            tick();
            model_clear(1'b0);
         end
         eh = model_access(wr, a);
         run_xact($sformatf("rnd%0d", i), wr, a, d, eh);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
